// File: rtl/cmd_framer_if.sv
// Byte, frame and response signals between cmd_framer,
// the UART transceiver and the command processor.
interface cmd_framer_if;
    logic        rx_rdy;
    logic [7:0]  rx_data;
    logic        clr_rx_rdy;
    logic        cmd_rdy;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        clr_cmd_rdy;
    logic        frame_err;
    logic [7:0]  resp;
    logic        send_resp;
    logic [7:0]  tx_data;
    logic        trmt;
    logic        tx_done;
    logic        resp_sent;

    modport master (
        input  rx_rdy, rx_data, clr_cmd_rdy,
        input  resp, send_resp, tx_done,
        output clr_rx_rdy, cmd_rdy, cmd, data,
        output frame_err, tx_data, trmt, resp_sent
    );

    modport slave (
        output rx_rdy, rx_data, clr_cmd_rdy,
        output resp, send_resp, tx_done,
        input  clr_rx_rdy, cmd_rdy, cmd, data,
        input  frame_err, tx_data, trmt, resp_sent
    );
endinterface

// File: rtl/cmd_framer.sv
// Assembles 3-byte packets into cmd/data and returns
// response bytes through a one-deep pending buffer.
module cmd_framer #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input logic          clk,
    input logic          rst,
    cmd_framer_if.master bus
);
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_CMD = 2'd0,
        WAIT_HI  = 2'd1,
        WAIT_LO  = 2'd2
    } rx_state_e;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_BUSY = 1'b1
    } tx_state_e;

    rx_state_e   rx_state_q, rx_state_d;
    tx_state_e   tx_state_q, tx_state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]  sh_cmd_q, sh_cmd_d;
    logic [7:0]  sh_hi_q, sh_hi_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [15:0] data_q, data_d;
    logic        cmd_rdy_q, cmd_rdy_d;
    logic        frame_err_q, frame_err_d;
    logic        pend_vld_q, pend_vld_d;
    logic [7:0]  pend_q, pend_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        trmt_q, trmt_d;
    logic        resp_sent_q, resp_sent_d;
    logic        accept;
    logic        expire;

    // Accept strobe; an opcode waits while an unconsumed frame is held
    always_comb begin
        accept = bus.rx_rdy &&
                 ((rx_state_q != WAIT_CMD) || !cmd_rdy_q || bus.clr_cmd_rdy);
        expire = (rx_state_q != WAIT_CMD) && !accept && (cnt_q == TERM);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q  <= WAIT_CMD;
            tx_state_q  <= TX_IDLE;
            cnt_q       <= '0;
            sh_cmd_q    <= '0;
            sh_hi_q     <= '0;
            cmd_q       <= '0;
            data_q      <= '0;
            cmd_rdy_q   <= 1'b0;
            frame_err_q <= 1'b0;
            pend_vld_q  <= 1'b0;
            pend_q      <= '0;
            tx_data_q   <= '0;
            trmt_q      <= 1'b0;
            resp_sent_q <= 1'b0;
        end else begin
            rx_state_q  <= rx_state_d;
            tx_state_q  <= tx_state_d;
            cnt_q       <= cnt_d;
            sh_cmd_q    <= sh_cmd_d;
            sh_hi_q     <= sh_hi_d;
            cmd_q       <= cmd_d;
            data_q      <= data_d;
            cmd_rdy_q   <= cmd_rdy_d;
            frame_err_q <= frame_err_d;
            pend_vld_q  <= pend_vld_d;
            pend_q      <= pend_d;
            tx_data_q   <= tx_data_d;
            trmt_q      <= trmt_d;
            resp_sent_q <= resp_sent_d;
        end
    end

    // RX next state: advance per accepted byte, fall back on timeout
    always_comb begin
        rx_state_d = rx_state_q;
        if (expire) begin
            rx_state_d = WAIT_CMD;
        end else if (accept) begin
            case (rx_state_q)
                WAIT_CMD: rx_state_d = WAIT_HI;
                WAIT_HI:  rx_state_d = WAIT_LO;
                WAIT_LO:  rx_state_d = WAIT_CMD;
                default:  rx_state_d = WAIT_CMD;
            endcase
        end
    end

    // RX datapath: shadow bytes, frame publish and idle counter
    always_comb begin
        sh_cmd_d    = sh_cmd_q;
        sh_hi_d     = sh_hi_q;
        cmd_d       = cmd_q;
        data_d      = data_q;
        cmd_rdy_d   = cmd_rdy_q && !bus.clr_cmd_rdy;
        frame_err_d = expire;
        if ((rx_state_q == WAIT_CMD) || accept || expire) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        if (expire) begin
            sh_cmd_d = '0;
            sh_hi_d  = '0;
        end else if (accept) begin
            case (rx_state_q)
                WAIT_CMD: sh_cmd_d = bus.rx_data;
                WAIT_HI:  sh_hi_d  = bus.rx_data;
                WAIT_LO: begin
                    cmd_d     = sh_cmd_q;
                    data_d    = {sh_hi_q, bus.rx_data};
                    cmd_rdy_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // TX next state: stay busy while a byte is in flight or queued
    always_comb begin
        tx_state_d = tx_state_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (bus.send_resp) tx_state_d = TX_BUSY;
            end
            TX_BUSY: begin
                if (bus.tx_done && !pend_vld_q && !bus.send_resp)
                    tx_state_d = TX_IDLE;
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // TX outputs: issue bytes, hold one pending, report completions
    always_comb begin
        pend_vld_d  = pend_vld_q;
        pend_d      = pend_q;
        tx_data_d   = tx_data_q;
        trmt_d      = 1'b0;
        resp_sent_d = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (bus.send_resp) begin
                    tx_data_d = bus.resp;
                    trmt_d    = 1'b1;
                end
            end
            TX_BUSY: begin
                if (bus.tx_done) begin
                    resp_sent_d = 1'b1;
                    if (pend_vld_q) begin
                        tx_data_d  = pend_q;
                        trmt_d     = 1'b1;
                        pend_vld_d = bus.send_resp;
                        if (bus.send_resp) pend_d = bus.resp;
                    end else if (bus.send_resp) begin
                        tx_data_d = bus.resp;
                        trmt_d    = 1'b1;
                    end
                end else if (bus.send_resp) begin
                    pend_vld_d = 1'b1;
                    pend_d     = bus.resp;
                end
            end
            default: ;
        endcase
    end

    assign bus.clr_rx_rdy = accept;
    assign bus.cmd_rdy    = cmd_rdy_q;
    assign bus.cmd        = cmd_q;
    assign bus.data       = data_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.tx_data    = tx_data_q;
    assign bus.trmt       = trmt_q;
    assign bus.resp_sent  = resp_sent_q;
endmodule

// File: tb/tb_cmd_framer.sv
// Directed bench for cmd_framer: framing, timeout,
// backpressure, responses and reset.
module tb_cmd_framer;
    localparam int T = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cmd_framer_if if_s ();
    cmd_framer_if if_b ();

    cmd_framer #(.TIMEOUT_CYCLES(T)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (if_s.master)
    );

    cmd_framer u_big (
        .clk (clk),
        .rst (rst),
        .bus (if_b.master)
    );

    int vectors     = 0;
    int miscompares = 0;
    logic [7:0] txq[$];
    int rs_cnt  = 0;
    int fe_cnt  = 0;
    int tx_left = 0;
    bit tx_busy = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input bit big, input logic [7:0] b,
                             input string tag);
        if (big) begin
            if_b.rx_rdy  = 1'b1;
            if_b.rx_data = b;
            #1;
            chk(tag, {31'd0, if_b.clr_rx_rdy}, 32'd1);
        end else begin
            if_s.rx_rdy  = 1'b1;
            if_s.rx_data = b;
            #1;
            chk(tag, {31'd0, if_s.clr_rx_rdy}, 32'd1);
        end
        @(posedge clk);
        #1;
        if_b.rx_rdy = 1'b0;
        if_s.rx_rdy = 1'b0;
    endtask

    // Transmitter model: tx_done 200 cycles after each trmt
    initial begin
        if_s.tx_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if_s.tx_done = 1'b0;
            if (rst) begin
                tx_busy = 1'b0;
            end else begin
                if (if_s.resp_sent) rs_cnt++;
                if (if_s.frame_err) fe_cnt++;
                if (tx_busy) begin
                    tx_left--;
                    if (tx_left == 0) begin
                        if_s.tx_done = 1'b1;
                        tx_busy      = 1'b0;
                    end
                end
                if (if_s.trmt) begin
                    txq.push_back(if_s.tx_data);
                    tx_busy = 1'b1;
                    tx_left = 200;
                end
            end
        end
    end

    initial begin
        int first;
        int n_fe;
        int n_cr;
        int bad;
        int rs0;
        int fe0;

        if_s.rx_rdy = 0; if_s.rx_data = 0; if_s.clr_cmd_rdy = 0;
        if_s.resp = 0; if_s.send_resp = 0;
        if_b.rx_rdy = 0; if_b.rx_data = 0; if_b.clr_cmd_rdy = 0;
        if_b.resp = 0; if_b.send_resp = 0; if_b.tx_done = 0;

        // reset state
        tick(3);
        chk("rst_ctl", {if_s.cmd_rdy, if_s.frame_err, if_s.trmt,
                        if_s.resp_sent, if_s.clr_rx_rdy}, 32'd0);
        chk("rst_bytes", {if_s.cmd, if_s.tx_data, if_s.data}, 32'd0);
        rst = 1'b0;
        tick(2);

        // basic frame with 1000-cycle gaps on default-timeout instance
        send_byte(1, 8'h05, "b_acc0");
        tick(1000);
        send_byte(1, 8'h00, "b_acc1");
        tick(1000);
        chk("b_rdy_early", {31'd0, if_b.cmd_rdy}, 32'd0);
        send_byte(1, 8'h4F, "b_acc2");
        chk("b_rdy", {31'd0, if_b.cmd_rdy}, 32'd1);
        chk("b_cmd", {24'd0, if_b.cmd}, 32'h05);
        chk("b_data", {16'd0, if_b.data}, 32'h004F);
        if_b.clr_cmd_rdy = 1'b1;
        tick(1);
        if_b.clr_cmd_rdy = 1'b0;
        chk("b_clr", {31'd0, if_b.cmd_rdy}, 32'd0);
        chk("b_hold", {8'd0, if_b.cmd, if_b.data}, 32'h0005004F);

        // timeout discards partial frame
        send_byte(0, 8'h02, "to_acc0");
        send_byte(0, 8'h00, "to_acc1");
        first = -1;
        n_fe  = 0;
        n_cr  = 0;
        for (int k = 0; k < 100; k++) begin
            if (if_s.frame_err) begin
                n_fe++;
                if (first < 0) first = k;
            end
            if (if_s.cmd_rdy) n_cr++;
            tick(1);
        end
        chk("to_when", first, T);
        chk("to_pulses", n_fe, 1);
        chk("to_no_rdy", n_cr, 0);
        send_byte(0, 8'h03, "to_acc2");
        send_byte(0, 8'h00, "to_acc3");
        send_byte(0, 8'h40, "to_acc4");
        chk("to_rdy", {31'd0, if_s.cmd_rdy}, 32'd1);
        chk("to_frame", {8'd0, if_s.cmd, if_s.data}, 32'h00030040);
        if_s.clr_cmd_rdy = 1'b1;
        tick(1);
        if_s.clr_cmd_rdy = 1'b0;

        // backpressure on a held frame
        send_byte(0, 8'h08, "bp_acc0");
        send_byte(0, 8'h04, "bp_acc1");
        send_byte(0, 8'h20, "bp_acc2");
        chk("bp_frame", {7'd0, if_s.cmd_rdy, if_s.cmd, if_s.data},
            32'h01080420);
        if_s.rx_rdy  = 1'b1;
        if_s.rx_data = 8'h06;
        bad = 0;
        for (int k = 0; k < 50; k++) begin
            tick(1);
            if (if_s.clr_rx_rdy) bad++;
        end
        chk("bp_stall", bad, 0);
        if_s.clr_cmd_rdy = 1'b1;
        #1;
        chk("bp_release", {31'd0, if_s.clr_rx_rdy}, 32'd1);
        @(posedge clk);
        #1;
        if_s.clr_cmd_rdy = 1'b0;
        if_s.rx_rdy      = 1'b0;
        chk("bp_cleared", {31'd0, if_s.cmd_rdy}, 32'd0);
        chk("bp_partial", {8'd0, if_s.cmd, if_s.data}, 32'h00080420);
        send_byte(0, 8'hF0, "bp_acc3");
        send_byte(0, 8'hF0, "bp_acc4");
        chk("bp_new", {7'd0, if_s.cmd_rdy, if_s.cmd, if_s.data},
            32'h0106F0F0);
        if_s.clr_cmd_rdy = 1'b1;
        tick(1);
        if_s.clr_cmd_rdy = 1'b0;

        // responses with last-write-wins pending buffer
        txq.delete();
        rs0 = rs_cnt;
        if_s.resp      = 8'hA5;
        if_s.send_resp = 1'b1;
        tick(1);
        if_s.send_resp = 1'b0;
        chk("tx_trmt", {23'd0, if_s.trmt, if_s.tx_data}, 32'h1A5);
        tick(1);
        chk("tx_trmt_low", {31'd0, if_s.trmt}, 32'd0);
        tick(5);
        if_s.resp      = 8'h0A;
        if_s.send_resp = 1'b1;
        tick(1);
        if_s.send_resp = 1'b0;
        tick(5);
        if_s.resp      = 8'h0B;
        if_s.send_resp = 1'b1;
        tick(1);
        if_s.send_resp = 1'b0;
        chk("tx_busy_hold", {23'd0, if_s.trmt, if_s.tx_data}, 32'h0A5);
        tick(500);
        chk("tx_count", txq.size(), 2);
        if (txq.size() >= 2) begin
            chk("tx_byte0", {24'd0, txq[0]}, 32'hA5);
            chk("tx_byte1", {24'd0, txq[1]}, 32'h0B);
        end
        chk("tx_sent", rs_cnt - rs0, 2);

        // reset mid-frame and mid-transmit
        send_byte(0, 8'h07, "rs_acc0");
        send_byte(0, 8'h00, "rs_acc1");
        if_s.resp      = 8'h3C;
        if_s.send_resp = 1'b1;
        tick(1);
        if_s.send_resp = 1'b0;
        tick(10);
        rst = 1'b1;
        tick(1);
        chk("rs_ctl", {if_s.cmd_rdy, if_s.frame_err, if_s.trmt,
                       if_s.resp_sent}, 32'd0);
        chk("rs_bytes", {if_s.cmd, if_s.tx_data, if_s.data}, 32'd0);
        tick(1);
        rst = 1'b0;
        rs0 = rs_cnt;
        tick(300);
        chk("rs_no_sent", rs_cnt - rs0, 0);
        send_byte(0, 8'h07, "rs_acc2");
        send_byte(0, 8'h00, "rs_acc3");
        send_byte(0, 8'h00, "rs_acc4");
        chk("rs_frame", {7'd0, if_s.cmd_rdy, if_s.cmd, if_s.data},
            32'h01070000);
        if_s.clr_cmd_rdy = 1'b1;
        tick(1);
        if_s.clr_cmd_rdy = 1'b0;

        // low byte lands in the terminal timeout cycle
        fe0 = fe_cnt;
        send_byte(0, 8'h02, "tm_acc0");
        send_byte(0, 8'h12, "tm_acc1");
        tick(T - 1);
        send_byte(0, 8'h34, "tm_acc2");
        chk("tm_frame", {7'd0, if_s.cmd_rdy, if_s.cmd, if_s.data},
            32'h01021234);
        tick(3);
        chk("tm_no_err", fe_cnt - fe0, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/cmd_framer.md
# cmd_framer

Byte-to-command framer between the copter's UART byte transceiver and the command processor. It assembles each 3-byte wireless packet (opcode, data high byte, data low byte) into a held `cmd`/`data` pair flagged by `cmd_rdy`, and it returns one-byte responses to the UART transmitter through a one-deep pending buffer. An inter-byte timeout resynchronises framing after a lost byte.

## Interface
- `TIMEOUT_CYCLES`, 1_000_000: number of idle clocks mid-frame before the partial frame is discarded (20 ms at 50 MHz). Counter width is ceil(log2(TIMEOUT_CYCLES)).
- `clk`  in  1  system clock. One clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `rx_rdy`  in  1  UART receiver holds a byte.
- `rx_data`  in  8  received byte.
- `clr_rx_rdy`  out  1  combinational accept strobe; high in the cycle a byte is taken.
- `cmd_rdy`  out  1  level; complete frame held on `cmd`/`data`.
- `cmd`  out  8  opcode of the last complete frame.
- `data`  out  16  {high byte, low byte} of the last complete frame.
- `clr_cmd_rdy`  in  1  command processor consumed the frame.
- `frame_err`  out  1  one-cycle pulse when a partial frame is discarded on timeout.
- `resp`  in  8  response byte.
- `send_resp`  in  1  one-cycle request to transmit `resp`.
- `tx_data`  out  8  byte to the UART transmitter.
- `trmt`  out  1  one-cycle transmit start.
- `tx_done`  in  1  transmitter finished its byte.
- `resp_sent`  out  1  one-cycle pulse per completed response.

## Operation
- All registered outputs reset to 0: `cmd_rdy`, `cmd`, `data`, `frame_err`, `tx_data`, `trmt`, `resp_sent`. Both state machines return to their idle states, the pending buffer is emptied, and the timeout counter is cleared.
- RX FSM states are WAIT_CMD, WAIT_HI and WAIT_LO.
  - In WAIT_CMD, a byte is accepted only if `rx_rdy` is high and either `cmd_rdy`=0 or `clr_cmd_rdy`=1. The byte goes to a shadow opcode register and the FSM moves to WAIT_HI. Otherwise `clr_rx_rdy` stays 0 and the byte waits in the UART.
  - In WAIT_HI, `rx_rdy` latches a shadow high byte and the FSM moves to WAIT_LO.
  - In WAIT_LO, `rx_rdy` loads `cmd` from the shadow opcode, loads `data` from {shadow high, rx_data}, sets `cmd_rdy`, and returns the FSM to WAIT_CMD.
  - In WAIT_HI and WAIT_LO, bytes are always accepted.
- `clr_rx_rdy` is high exactly in the cycles where a byte is accepted.
- `cmd` and `data` change only when a frame completes. Partial frames never disturb them.
- `cmd_rdy` clears on `clr_cmd_rdy`. `clr_cmd_rdy` while `cmd_rdy`=0 has no effect.
- Timeout: the counter clears on every accepted byte and whenever the FSM is in WAIT_CMD, and increments in WAIT_HI and WAIT_LO. When it reaches TIMEOUT_CYCLES-1 with no byte that cycle, the FSM returns to WAIT_CMD, `frame_err` pulses, and the shadow registers are discarded. A byte accepted in the terminal cycle wins, and no error is raised.
- TX FSM states are TX_IDLE and TX_BUSY.
  - In TX_IDLE, `send_resp` loads `tx_data`=`resp`, asserts `trmt` for one cycle and moves to TX_BUSY.
  - In TX_BUSY, `send_resp` writes the pending buffer. Last write wins: an earlier unsent pending byte is overwritten.
  - `tx_done` pulses `resp_sent`. If the pending buffer is full, it issues the pending byte (`tx_data` load plus `trmt`) and stays in TX_BUSY. Otherwise it returns to TX_IDLE.
  - If `send_resp` and `tx_done` occur in the same cycle with pending empty, the new byte is issued directly.
- The RX and TX paths are independent; no ordering exists between them.

## Timing
- The byte accept is combinational, at cycle N.
- The low byte accepted at N gives `cmd_rdy`=1 with valid `cmd`/`data` at N+1.
- `clr_cmd_rdy` at N gives `cmd_rdy`=0 at N+1.
- `send_resp` at N in TX_IDLE gives `trmt`=1 and `tx_data`=`resp` at N+1. `trmt` is low again at N+2.
- `tx_done` at M gives `resp_sent` at M+1, plus `trmt` at M+1 if a byte is pending.
- For `frame_err`: the last accepted byte at N with no further bytes gives `frame_err` at N+TIMEOUT_CYCLES+1 (counter start N+1 plus one register stage). This is checked against the parameter, not a hard-coded number.
- Reset in mid-frame or mid-transmit gives all outputs 0 the next cycle. Any UART transfer in flight is abandoned, with no `resp_sent`.

## Test plan
- Send bytes 0x05, 0x00, 0x4F with gaps of 1000 cycles → `cmd`=0x05, `data`=0x004F, `cmd_rdy`=1 one cycle after the third accept. Apply `clr_cmd_rdy` → `cmd_rdy`=0 next cycle, and `cmd`/`data` unchanged.
- With `TIMEOUT_CYCLES`=64, send 0x02, 0x00, then idle 100 cycles → a single `frame_err` pulse and no `cmd_rdy`. Then send 0x03, 0x00, 0x40 → `cmd`=0x03, `data`=0x0040.
- Backpressure: leave frame 0x08/0x0420 unacknowledged and present 0x06 on `rx_rdy` → `clr_rx_rdy`=0 for 50 cycles. Pulse `clr_cmd_rdy` → 0x06 is accepted that same cycle. Complete 0xF0, 0xF0 → `cmd`=0x06, `data`=0xF0F0.
- Responses: `send_resp` 0xA5, then 0x0A, then 0x0B while busy; the transmitter model raises `tx_done` after 200 cycles → bytes transmitted are exactly 0xA5 then 0x0B, with two `resp_sent` pulses.
- Assert `rst` after 0x07, 0x00 and mid-transmit → all outputs 0 next cycle. Then frame 0x07, 0x00, 0x00 → `cmd`=0x07, `data`=0x0000, with no stale high byte.
- Send 0x02, 0x12 at cycle 0 and the low byte 0x34 exactly in the terminal timeout cycle → the frame completes with `data`=0x1234 and no `frame_err`.
